// File: rtl/tl45_pkg.sv
// Shared types and constants for the TL45 issue/hazard controller.
package tl45_pkg;

    localparam logic [4:0] OP_NOP = 5'h00;
    localparam logic [4:0] OP_LW  = 5'h14;
    localparam logic [4:0] OP_SW  = 5'h15;

    // One shadow-pipeline entry: an in-flight destination register.
    typedef struct packed {
        logic       valid;
        logic [3:0] dr;
        logic       is_load;
    } slot_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALT
    } state_e;

endpackage

// File: rtl/tl45_reg_match.sv
// Flags a dependency between one in-flight slot and the decode sources.
module tl45_reg_match
    import tl45_pkg::*;
(
    input  slot_t      slot,
    input  logic [3:0] sr1,
    input  logic [3:0] sr2,
    output logic       match
);

    logic sr1_hit;
    logic sr2_hit;

    // r0 is hardwired, so it never creates a dependency on either side.
    always_comb begin
        sr1_hit = (sr1 != 4'd0) && (sr1 == slot.dr);
        sr2_hit = (sr2 != 4'd0) && (sr2 == slot.dr);
        match   = slot.valid && (slot.dr != 4'd0) && (sr1_hit || sr2_hit);
    end

endmodule

// File: rtl/tl45_issue_ctrl.sv
// Issue/hazard controller: decides each cycle whether the decoded
// instruction may enter EX, tracking in-flight destinations in a shadow pipe.
module tl45_issue_ctrl
    import tl45_pkg::*;
#(
    parameter int unsigned DEPTH  = 3,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_dec_valid,
    input  logic [4:0]  i_dec_opcode,
    input  logic [3:0]  i_dec_dr,
    input  logic [3:0]  i_dec_sr1,
    input  logic [3:0]  i_dec_sr2,
    input  logic        i_dec_err,
    input  logic        i_mem_stall,
    input  logic        i_br_flush,
    output logic        o_dec_stall,
    output logic        o_pipe_flush,
    output logic        o_issue,
    output logic        o_halted,
    output logic [31:0] o_stall_cnt
);

    // S[1] = EX ... S[DEPTH] = WB
    slot_t       slot_q [1:DEPTH];
    state_e      state_q;
    logic        halted_q;
    logic [31:0] stall_cnt_q;

    logic [DEPTH:1] match;
    logic           any_match;
    logic           all_empty;
    logic           hazard;
    logic           running;
    slot_t          new_slot;

    for (genvar k = 1; k <= DEPTH; k++) begin : g_match
        tl45_reg_match u_match (
            .slot  (slot_q[k]),
            .sr1   (i_dec_sr1),
            .sr2   (i_dec_sr2),
            .match (match[k])
        );
    end

    // WB slot writes before read, so it is excluded from the no-forward check.
    always_comb begin
        any_match = 1'b0;
        all_empty = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            if (k < DEPTH) begin
                any_match = any_match | match[k];
            end
            all_empty = all_empty & ~slot_q[k].valid;
        end
    end

    // Hazard detection and the combinational issue handshake.
    always_comb begin
        running = (state_q == RUN);
        hazard  = 1'b0;
        if (i_dec_valid && running) begin
            if (FWD_EN) begin
                hazard = match[1] & slot_q[1].is_load;
            end else begin
                hazard = any_match;
            end
        end
        o_dec_stall  = i_mem_stall | hazard | ~running;
        o_issue      = i_dec_valid & ~o_dec_stall & ~i_br_flush & running;
        o_pipe_flush = i_br_flush;
        new_slot.valid   = 1'b1;
        new_slot.dr      = i_dec_dr;
        new_slot.is_load = (i_dec_opcode == OP_LW);
    end

    // Shadow pipe: frozen on mem stall, otherwise shifts with issue or bubble.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                slot_q[k] <= '0;
            end
        end else if (!i_mem_stall) begin
            for (int k = 2; k <= DEPTH; k++) begin
                slot_q[k] <= slot_q[k-1];
            end
            slot_q[1] <= o_issue ? new_slot : '0;
        end
    end

    // Saturating count of hazard-stall cycles (mem-stall cycles excluded).
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stall_cnt_q <= '0;
        end else if (hazard && !i_mem_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    // Error FSM: wrong-path errors (with flush) are ignored; halt once drained.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (i_dec_err && !i_mem_stall && !i_br_flush) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!i_mem_stall && all_empty) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end
                end
                HALT: begin
                    state_q  <= HALT;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_halted    = halted_q;
    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_tl45_issue_ctrl.sv
// Directed bench: one forwarding and one non-forwarding controller share
// stimulus; expected outputs for both are queued per cycle and checked.
module tb_tl45_issue_ctrl;
    import tl45_pkg::*;

    localparam logic [4:0] OP_ADD = 5'h01;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_dec_valid;
    logic [4:0]  i_dec_opcode;
    logic [3:0]  i_dec_dr;
    logic [3:0]  i_dec_sr1;
    logic [3:0]  i_dec_sr2;
    logic        i_dec_err;
    logic        i_mem_stall;
    logic        i_br_flush;

    logic        stall_a, flush_a, issue_a, halted_a;
    logic [31:0] cnt_a;
    logic        stall_b, flush_b, issue_b, halted_b;
    logic [31:0] cnt_b;

    tl45_issue_ctrl #(.DEPTH(3), .FWD_EN(1'b1)) dut_a (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_dec_valid  (i_dec_valid),
        .i_dec_opcode (i_dec_opcode),
        .i_dec_dr     (i_dec_dr),
        .i_dec_sr1    (i_dec_sr1),
        .i_dec_sr2    (i_dec_sr2),
        .i_dec_err    (i_dec_err),
        .i_mem_stall  (i_mem_stall),
        .i_br_flush   (i_br_flush),
        .o_dec_stall  (stall_a),
        .o_pipe_flush (flush_a),
        .o_issue      (issue_a),
        .o_halted     (halted_a),
        .o_stall_cnt  (cnt_a)
    );

    tl45_issue_ctrl #(.DEPTH(3), .FWD_EN(1'b0)) dut_b (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_dec_valid  (i_dec_valid),
        .i_dec_opcode (i_dec_opcode),
        .i_dec_dr     (i_dec_dr),
        .i_dec_sr1    (i_dec_sr1),
        .i_dec_sr2    (i_dec_sr2),
        .i_dec_err    (i_dec_err),
        .i_mem_stall  (i_mem_stall),
        .i_br_flush   (i_br_flush),
        .o_dec_stall  (stall_b),
        .o_pipe_flush (flush_b),
        .o_issue      (issue_b),
        .o_halted     (halted_b),
        .o_stall_cnt  (cnt_b)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        sa;
        logic        ia;
        logic [31:0] ca;
        logic        sb;
        logic        ib;
        logic [31:0] cb;
        logic        ha;
        logic        hb;
        logic        fl;
    } exp_t;

    exp_t  sb_q[$];
    string tag;
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s %s: got %0h want %0h", tag, name, obs, exp);
        end
    endtask

    // Pop the expectation queued for this cycle and compare both controllers.
    task automatic check_outputs();
        exp_t e;
        total = total + 1;
        assert (sb_q.size() != 0) else begin
            bad = bad + 1;
            $error("FAIL %s queue: got empty want entry", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("stall_a",  {31'd0, stall_a},  {31'd0, e.sa});
            chk("issue_a",  {31'd0, issue_a},  {31'd0, e.ia});
            chk("cnt_a",    cnt_a,             e.ca);
            chk("halted_a", {31'd0, halted_a}, {31'd0, e.ha});
            chk("flush_a",  {31'd0, flush_a},  {31'd0, e.fl});
            chk("stall_b",  {31'd0, stall_b},  {31'd0, e.sb});
            chk("issue_b",  {31'd0, issue_b},  {31'd0, e.ib});
            chk("cnt_b",    cnt_b,             e.cb);
            chk("halted_b", {31'd0, halted_b}, {31'd0, e.hb});
            chk("flush_b",  {31'd0, flush_b},  {31'd0, e.fl});
        end
    endtask

    // One cycle: drive inputs, queue expectations, sample at negedge.
    task automatic cyc(input string t, input logic v, input logic [4:0] op,
                       input logic [3:0] dr, input logic [3:0] s1, input logic [3:0] s2,
                       input logic err, input logic ms, input logic fl,
                       input logic sa, input logic ia, input int ca,
                       input logic sb, input logic ib, input int cb,
                       input logic ha, input logic hb);
        exp_t e;
        tag          = t;
        i_dec_valid  = v;
        i_dec_opcode = op;
        i_dec_dr     = dr;
        i_dec_sr1    = s1;
        i_dec_sr2    = s2;
        i_dec_err    = err;
        i_mem_stall  = ms;
        i_br_flush   = fl;
        e = '{sa: sa, ia: ia, ca: ca, sb: sb, ib: ib, cb: cb, ha: ha, hb: hb, fl: fl};
        sb_q.push_back(e);
        @(negedge i_clk);
        check_outputs();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset(input string t);
        exp_t e;
        tag          = t;
        i_reset      = 1'b1;
        i_dec_valid  = 1'b0;
        i_dec_opcode = OP_NOP;
        i_dec_dr     = '0;
        i_dec_sr1    = '0;
        i_dec_sr2    = '0;
        i_dec_err    = 1'b0;
        i_mem_stall  = 1'b0;
        i_br_flush   = 1'b0;
        e = '0;
        sb_q.push_back(e);
        @(negedge i_clk);
        check_outputs();
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
    endtask

    initial begin
        do_reset("reset");

        // ALU -> ALU dependency: free with forwarding, DEPTH-1 stalls without.
        cyc("alu1",   1, OP_ADD, 3, 1, 2, 0, 0, 0,  0, 1, 0,  0, 1, 0,  0, 0);
        cyc("alu2",   1, OP_ADD, 4, 3, 3, 0, 0, 0,  0, 1, 0,  1, 0, 0,  0, 0);
        cyc("alu3",   1, OP_ADD, 4, 3, 3, 0, 0, 0,  0, 1, 0,  1, 0, 1,  0, 0);
        cyc("alu4",   1, OP_ADD, 4, 3, 3, 0, 0, 0,  0, 1, 0,  0, 1, 2,  0, 0);
        cyc("alu5",   0, OP_NOP, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 2,  0, 0);

        // Load-use: one stall with forwarding, two without; r0 never stalls.
        do_reset("reset2");
        cyc("lu1",    1, OP_LW,  5, 1, 0, 0, 0, 0,  0, 1, 0,  0, 1, 0,  0, 0);
        cyc("lu2",    1, OP_ADD, 6, 5, 0, 0, 0, 0,  1, 0, 0,  1, 0, 0,  0, 0);
        cyc("lu3",    1, OP_ADD, 6, 5, 0, 0, 0, 0,  0, 1, 1,  1, 0, 1,  0, 0);
        cyc("lu4",    1, OP_ADD, 6, 5, 0, 0, 0, 0,  0, 1, 1,  0, 1, 2,  0, 0);
        cyc("lu5",    0, OP_NOP, 0, 0, 0, 0, 0, 0,  0, 0, 1,  0, 0, 2,  0, 0);
        cyc("r0dst",  1, OP_ADD, 0, 2, 0, 0, 0, 0,  0, 1, 1,  0, 1, 2,  0, 0);
        cyc("r0src",  1, OP_ADD, 7, 0, 0, 0, 0, 0,  0, 1, 1,  0, 1, 2,  0, 0);
        cyc("r0idle", 0, OP_NOP, 0, 0, 0, 0, 0, 0,  0, 0, 1,  0, 0, 2,  0, 0);

        // Mem stall freezes slots and the counter while a hazard is pending.
        do_reset("reset3");
        cyc("ms1",    1, OP_LW,  5, 1, 0, 0, 0, 0,  0, 1, 0,  0, 1, 0,  0, 0);
        cyc("ms2",    1, OP_ADD, 6, 5, 0, 0, 1, 0,  1, 0, 0,  1, 0, 0,  0, 0);
        cyc("ms3",    1, OP_ADD, 6, 5, 0, 0, 1, 0,  1, 0, 0,  1, 0, 0,  0, 0);
        cyc("ms4",    1, OP_ADD, 6, 5, 0, 0, 1, 0,  1, 0, 0,  1, 0, 0,  0, 0);
        cyc("ms5",    1, OP_ADD, 6, 5, 0, 0, 0, 0,  1, 0, 0,  1, 0, 0,  0, 0);
        cyc("ms6",    1, OP_ADD, 6, 5, 0, 0, 0, 0,  0, 1, 1,  1, 0, 1,  0, 0);
        cyc("ms7",    1, OP_ADD, 6, 5, 0, 0, 0, 0,  0, 1, 1,  0, 1, 2,  0, 0);

        // Flush squashes a would-hazard instruction; S[1] becomes a bubble.
        do_reset("reset4");
        cyc("fl1",    1, OP_LW,  5, 1, 0, 0, 0, 0,  0, 1, 0,  0, 1, 0,  0, 0);
        cyc("fl2",    1, OP_ADD, 6, 5, 0, 0, 0, 1,  1, 0, 0,  1, 0, 0,  0, 0);
        cyc("fl3",    1, OP_ADD, 7, 6, 6, 0, 0, 0,  0, 1, 1,  0, 1, 1,  0, 0);
        cyc("wperr",  0, OP_NOP, 0, 0, 0, 1, 0, 1,  0, 0, 1,  0, 0, 1,  0, 0);
        cyc("wpnext", 1, OP_ADD, 8, 1, 1, 0, 0, 0,  0, 1, 1,  0, 1, 1,  0, 0);

        // Decode error with two valid slots: drain, then halt for good.
        do_reset("reset5");
        cyc("dr1",    1, OP_ADD, 3, 1, 2, 0, 0, 0,  0, 1, 0,  0, 1, 0,  0, 0);
        cyc("dr2",    1, OP_ADD, 4, 1, 1, 0, 0, 0,  0, 1, 0,  0, 1, 0,  0, 0);
        cyc("err",    0, OP_NOP, 0, 0, 0, 1, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0);
        cyc("drain1", 0, OP_NOP, 0, 0, 0, 0, 0, 0,  1, 0, 0,  1, 0, 0,  0, 0);
        cyc("drain2", 0, OP_NOP, 0, 0, 0, 0, 0, 0,  1, 0, 0,  1, 0, 0,  0, 0);
        cyc("drain3", 0, OP_NOP, 0, 0, 0, 0, 0, 0,  1, 0, 0,  1, 0, 0,  0, 0);
        cyc("halt1",  1, OP_ADD, 9, 1, 1, 0, 0, 1,  1, 0, 0,  1, 0, 0,  1, 1);
        cyc("halt2",  1, OP_ADD, 9, 1, 1, 0, 0, 0,  1, 0, 0,  1, 0, 0,  1, 1);

        // Reset mid-drain (slots frozen by mem stall) must leave empty slots.
        do_reset("reset6");
        cyc("rd1",    1, OP_ADD, 3, 1, 2, 0, 0, 0,  0, 1, 0,  0, 1, 0,  0, 0);
        cyc("rd2",    1, OP_ADD, 4, 1, 1, 0, 0, 0,  0, 1, 0,  0, 1, 0,  0, 0);
        cyc("rderr",  0, OP_NOP, 0, 0, 0, 1, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0);
        cyc("rdms",   0, OP_NOP, 0, 0, 0, 0, 1, 0,  1, 0, 0,  1, 0, 0,  0, 0);
        do_reset("rst_drain");
        cyc("after",  1, OP_ADD, 9, 4, 4, 0, 0, 0,  0, 1, 0,  0, 1, 0,  0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
